// File: rtl/math_multiplier_booth_radix_4_sequential.sv
// ---------------------------------------------------------------------------
// math_multiplier_booth_radix_4_sequential
//
// Purpose:
//   Iterative signed N x N multiplier using a single radix-4 Booth digit
//   stage. One Booth group (two multiplier bits) is retired per clock, so a
//   2N-bit two's-complement product is ready N/2 compute cycles after the
//   operands are accepted.
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_rst_n         synchronous active-low reset (highest priority)
//   i_valid         operand pair valid
//   o_ready         high in IDLE: operands can be accepted
//   i_multiplicand  signed multiplicand (N bits)
//   i_multiplier    signed multiplier (N bits)
//   i_abort         drops an in-flight operation (CALC or DONE)
//   o_busy          high in CALC or DONE
//   o_valid         product valid (DONE state)
//   i_ready         consumer accepts product
//   o_product       signed product (2N bits), held until the next result
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. Operands are taken only in IDLE; the
// product is offered in DONE and held stable until i_ready or i_abort.
// Nothing is accepted in the cycle a product is consumed.
// ---------------------------------------------------------------------------
module math_multiplier_booth_radix_4_sequential #(
    parameter int N = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_multiplicand,
    input  logic [N-1:0]     i_multiplier,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [2*N-1:0]   o_product
);

    // Booth recoding needs an even operand width and at least two groups.
    if (((N % 2) != 0) || (N < 4)) begin : g_bad_width
        $error("math_multiplier_booth_radix_4_sequential: N must be even and >= 4");
    end

    localparam int NI = N / 2;                       // number of Booth groups
    localparam int CW = (NI > 1) ? $clog2(NI) : 1;   // iteration counter width
    localparam logic [CW-1:0] LAST_ITER = CW'(NI - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [N+1:0]     mcand;    // multiplicand, sign-extended to N+2 bits
    logic [N:0]       sreg;     // multiplier with an implicit 0 below bit 0
    logic [2*N-1:0]   acc;      // running partial sum
    logic [CW-1:0]    iter;     // index of the Booth group being processed
    logic [2*N-1:0]   product;

    logic             last_iter;
    logic [N+1:0]     pp;       // selected partial product, N+2 bits
    logic [2*N-1:0]   pp_ext;
    logic [2*N-1:0]   pp_shifted;
    logic [2*N-1:0]   acc_sum;

    assign last_iter = (iter == LAST_ITER);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic. Abort beats the final CALC edge, so an aborted
    // operation never reaches DONE.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (i_abort) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_abort || i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Booth digit selection. The partial product is kept at N+2 bits so that
    // -2 * (-2^(N-1)) = +2^N is representable without overflow.
    // -----------------------------------------------------------------------
    always_comb begin
        pp = '0;
        case (sreg[2:0])
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = {mcand[N:0], 1'b0};
            3'b100:         pp = -{mcand[N:0], 1'b0};
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    // Sign-extend to the accumulator width and weight by 4^iter. Carries out
    // of bit 2N-1 are discarded; they cannot change the final product.
    assign pp_ext     = {{(N - 2){pp[N+1]}}, pp};
    assign pp_shifted = pp_ext << {iter, 1'b0};
    assign acc_sum    = acc + pp_shifted;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mcand   <= '0;
            sreg    <= '0;
            acc     <= '0;
            iter    <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        mcand <= {{2{i_multiplicand[N-1]}}, i_multiplicand};
                        sreg  <= {i_multiplier, 1'b0};
                        acc   <= '0;
                        iter  <= '0;
                    end
                end
                CALC: begin
                    if (!i_abort) begin
                        acc  <= acc_sum;
                        // Arithmetic shift keeps the multiplier sign for the
                        // upper groups.
                        sreg <= {{2{sreg[N]}}, sreg[N:2]};
                        iter <= iter + 1'b1;
                        if (last_iter) begin
                            product <= acc_sum;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_ready   = (state == IDLE);
    assign o_busy    = (state != IDLE);
    assign o_valid   = (state == DONE);
    assign o_product = product;

endmodule

// File: tb/tb_math_multiplier_booth_radix_4_sequential.sv
// ---------------------------------------------------------------------------
// tb_math_multiplier_booth_radix_4_sequential
//
// Directed vectors with literal expected products, followed by a random
// phase. A transaction-level model (accept -> N/2 cycles -> offer product ->
// consume/abort) predicts every output each cycle; a compare process checks
// the DUT against it on the falling edge.
// ---------------------------------------------------------------------------
module tb_math_multiplier_booth_radix_4_sequential;

    localparam int N = 8;
    localparam int W = 2 * N;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           i_valid;
    logic           o_ready;
    logic [N-1:0]   i_multiplicand;
    logic [N-1:0]   i_multiplier;
    logic           i_abort;
    logic           o_busy;
    logic           o_valid;
    logic           i_ready;
    logic [W-1:0]   o_product;

    math_multiplier_booth_radix_4_sequential #(.N(N)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .i_abort        (i_abort),
        .o_busy         (o_busy),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_product      (o_product)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p[W-1:0];
    endfunction

    // ---------------- reference model ----------------
    // Phases of one transaction as seen from outside the block.
    localparam int P_IDLE = 0;
    localparam int P_CALC = 1;
    localparam int P_DONE = 2;

    logic [W-1:0] exp_q[$];     // expected product of the in-flight operation
    int           m_phase  = P_IDLE;
    int           m_left   = 0;
    logic [W-1:0] m_prod   = '0;
    bit           model_live = 1'b0;
    int           m_taken  = 0;
    int           dut_taken = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_prod  = '0;
            exp_q.delete();
            model_live = 1'b1;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (i_valid) begin
                        exp_q.push_back(ref_mul(i_multiplicand, i_multiplier));
                        m_left  = N / 2;
                        m_phase = P_CALC;
                    end
                end
                P_CALC: begin
                    if (i_abort) begin
                        exp_q.delete();
                        m_phase = P_IDLE;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_prod  = exp_q[0];
                            m_phase = P_DONE;
                        end
                    end
                end
                default: begin
                    if (i_abort) begin
                        exp_q.delete();
                        m_phase = P_IDLE;
                    end else if (i_ready) begin
                        void'(exp_q.pop_front());
                        m_taken++;
                        m_phase = P_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_live) begin
            check("o_ready",   {63'd0, o_ready}, {63'd0, (m_phase == P_IDLE)});
            check("o_busy",    {63'd0, o_busy},  {63'd0, (m_phase != P_IDLE)});
            check("o_valid",   {63'd0, o_valid}, {63'd0, (m_phase == P_DONE)});
            check("o_product", 64'(o_product),   64'(m_prod));
            // Results actually handed over by the DUT on the coming edge.
            if (rst_n && o_valid && i_ready && !i_abort) dut_taken++;
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int stall, input logic [W-1:0] exp_lit);
        int cyc;
        i_valid        = 1'b1;
        i_multiplicand = a;
        i_multiplier   = b;
        i_ready        = (stall == 0);
        @(posedge clk); #1;                 // acceptance edge
        i_valid        = 1'b0;
        i_multiplicand = N'($urandom);      // must be ignored while busy
        i_multiplier   = N'($urandom);
        cyc = 0;
        while (!o_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'd4);
        check({name, " product"}, 64'(o_product), 64'(exp_lit));
        for (int k = 0; k < stall; k++) begin
            check({name, " stall valid"},   {63'd0, o_valid}, 64'd1);
            check({name, " stall ready"},   {63'd0, o_ready}, 64'd0);
            check({name, " stall product"}, 64'(o_product), 64'(exp_lit));
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check({name, " idle valid"}, {63'd0, o_valid}, 64'd0);
        check({name, " idle ready"}, {63'd0, o_ready}, 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n          = 1'b0;
        i_valid        = 1'b0;
        i_multiplicand = '0;
        i_multiplier   = '0;
        i_abort        = 1'b0;
        i_ready        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset o_valid",   {63'd0, o_valid}, 64'd0);
        check("reset o_busy",    {63'd0, o_busy},  64'd0);
        check("reset o_ready",   {63'd0, o_ready}, 64'd1);
        check("reset o_product", 64'(o_product),   64'd0);

        do_op("3x5",        8'd3,    8'd5,    0, 16'h000F);
        do_op("-128x-128",  8'h80,   8'h80,   0, 16'h4000);
        do_op("-128x127",   8'h80,   8'h7F,   0, 16'hC080);
        do_op("127x-1",     8'h7F,   8'hFF,   0, 16'hFF81);
        do_op("0x-77",      8'd0,    -8'sd77, 0, 16'h0000);
        do_op("7x-9 stall", 8'd7,    -8'sd9,  5, 16'hFFC1);

        // Abort on the 2nd CALC cycle of 100 x 100.
        i_valid = 1'b1; i_multiplicand = 8'd100; i_multiplier = 8'd100;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("abort busy",    {63'd0, o_busy},  64'd0);
        check("abort valid",   {63'd0, o_valid}, 64'd0);
        check("abort ready",   {63'd0, o_ready}, 64'd1);
        check("abort product", 64'(o_product),   64'hFFC1);
        repeat (6) begin
            @(posedge clk); #1;
            check("abort no valid", {63'd0, o_valid}, 64'd0);
        end
        do_op("2x2", 8'd2, 8'd2, 0, 16'h0004);

        // Reset on the 3rd CALC cycle.
        i_valid = 1'b1; i_multiplicand = 8'd50; i_multiplier = 8'd3;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst-mid valid",   {63'd0, o_valid}, 64'd0);
        check("rst-mid busy",    {63'd0, o_busy},  64'd0);
        check("rst-mid ready",   {63'd0, o_ready}, 64'd1);
        check("rst-mid product", 64'(o_product),   64'd0);
        do_op("12x-12", 8'd12, -8'sd12, 0, 16'hFF70);

        // Random phase: random operands, valid, stalls, rare aborts.
        for (int c = 0; c < 6000; c++) begin
            i_valid        = ($urandom_range(0, 3) != 0);
            i_multiplicand = N'($urandom);
            i_multiplier   = N'($urandom);
            i_ready        = ($urandom_range(0, 2) != 0);
            i_abort        = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_abort = 1'b0;
        i_ready = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1;
        check("results handed over", 64'(dut_taken), 64'(m_taken));
        check("random phase produced results", {63'd0, (m_taken > 100)}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: guarantees termination even if a driver loop misbehaves.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/math_multiplier_booth_radix_4_sequential.md
Name: math_multiplier_booth_radix_4_sequential

Overview:
Iterative signed N x N multiplier built around one radix-4 Booth digit stage. It retires one Booth group (2 multiplier bits) per clock and produces a 2N-bit two's-complement product after N/2 compute cycles. It uses a valid/ready handshake on both the operand side and the result side, and serves area-constrained datapaths where a combinational array multiplier is too large.

Parameters:
N, 8, operand width in bits, signed two's complement; must be even and >= 4 (elaboration-time check, error otherwise)

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  operand pair valid
o_ready  output  1  block can accept operands
i_multiplicand  input  N  signed multiplicand
i_multiplier  input  N  signed multiplier
i_abort  input  1  synchronous abort of an in-flight operation
o_busy  output  1  high in CALC or DONE
o_valid  output  1  product valid
i_ready  input  1  consumer accepts product
o_product  output  2N  signed product

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - state goes to IDLE; o_valid=0, o_busy=0, o_product=0.
  - Accumulator, counter and operand registers are cleared.
  - Reset takes priority over every other input, including mid-CALC and mid-DONE.
- States:
  - IDLE: o_ready=1. On i_valid && o_ready:
    - register multiplicand sign-extended to N+2 bits;
    - load multiplier shift register as {i_multiplier, 1'b0} (N+1 bits);
    - clear accumulator (2N bits) and iteration counter;
    - go to CALC.
  - CALC: o_ready=0, o_busy=1.
    - Each edge, form Booth group g = shift_reg[2:0] and select partial product P:
      000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
    - P is computed at N+2 bits so -2*(-2^(N-1)) = +2^N is exact.
    - accumulator += sign_extend_2N(P) << (2*iter).
    - shift_reg >>= 2 (arithmetic, keep sign); iter++.
    - On the edge processing iter = N/2-1: write the final sum to o_product, set o_valid=1, go to DONE.
  - DONE: o_valid=1, o_busy=1, o_ready=0.
    - o_product is held stable while i_ready=0.
    - On i_ready: o_valid=0, go to IDLE. No new operand is accepted in the same cycle, so o_ready is 0 during DONE.
- Latency:
  - Acceptance edge E0; CALC edges E1..E(N/2).
  - o_valid is high in the cycle following E(N/2), i.e. N/2 cycles after acceptance (4 for N=8).
  - Minimum issue interval is N/2+2 cycles.
- Arithmetic:
  - The product is exact for all operand pairs, including -2^(N-1) x -2^(N-1) = +2^(2N-2).
  - Accumulator wrap beyond 2N bits cannot occur for valid inputs; intermediate carries above bit 2N-1 are discarded.
- Abort:
  - i_abort high in CALC: return to IDLE next edge, o_valid stays 0, o_product unchanged.
  - i_abort high in DONE: drop the result (o_valid=0), go to IDLE.
  - i_abort in IDLE has no effect and does not block acceptance in the same cycle.
  - Abort wins over the final CALC edge, so no o_valid is produced.
- i_valid and operand changes outside IDLE are ignored.
- o_product updates only on CALC->DONE and on reset.

Test Plan:
- N=8: 3 x 5 with i_ready=1 -> o_valid exactly 4 cycles after acceptance, o_product=15; returns to IDLE next cycle, o_ready=1.
- Corner operands:
  - -128 x -128 -> 16384 (0x4000)
  - -128 x 127 -> -16256 (0xC080)
  - 127 x -1 -> -127 (0xFF81)
  - 0 x -77 -> 0
- Backpressure: 7 x -9 with i_ready low for 5 cycles -> o_valid and o_product=-63 stable throughout, o_ready=0; single-cycle i_ready -> IDLE next edge.
- Abort: assert i_abort on the 2nd CALC cycle of 100 x 100 -> IDLE next edge, o_valid never asserted, o_product keeps its previous value. Then 2 x 2 -> 4.
- Reset mid-operation: pull i_rst_n low on the 3rd CALC cycle -> next edge o_valid=0, o_busy=0, o_product=0, o_ready=1. A following 12 x -12 yields -144.
- Random: 10k random signed pairs with random i_ready stalls, N=8 and N=16 -> every product matches a reference signed multiply; 0 mismatches; handshake never drops or duplicates a result.
